// File: rtl/div_issue_ctrl.sv
// EX-stage issue/writeback controller for the iterative 32-bit divider.
// Holds start until ready, stalls EX meanwhile, pulses HI/LO write; drains the divider on flush.
module div_issue_ctrl #(
  parameter int WATCHDOG_CYCLES = 48
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        ex_div_valid,
  input  logic        ex_div_signed,
  input  logic [31:0] ex_opdata1,
  input  logic [31:0] ex_opdata2,
  input  logic        flush,
  input  logic        div_ready_i,
  input  logic [63:0] div_res_i,
  output logic        div_start_o,
  output logic        signed_div_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stall_req_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_timeout_o
);

  localparam int CW = $clog2(WATCHDOG_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            launch;
  logic            capture;
  logic            kill;
  logic [CW-1:0]   wd_cnt;

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    stall_req_o = 1'b0;
    launch      = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (ex_div_valid && !flush) begin
          stall_req_o = 1'b1;
          launch      = 1'b1;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        // Ready wins over a same-cycle flush; the kill flag then blocks the write.
        if (div_ready_i) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (flush) begin
          state_nxt = ABORT;
        end else begin
          stall_req_o = 1'b1;
        end
      end
      DONE: begin
        stall_req_o = ex_div_valid;
        state_nxt   = IDLE;
      end
      ABORT: begin
        stall_req_o = ex_div_valid;
        if (div_ready_i) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign hilo_we_o = (state == DONE) && !kill;

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      div_start_o   <= 1'b0;
      signed_div_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      hi_o          <= '0;
      lo_o          <= '0;
      kill          <= 1'b0;
    end else begin
      if (launch) begin
        div_start_o   <= 1'b1;
        signed_div_o  <= ex_div_signed;
        div_opdata1_o <= ex_opdata1;
        div_opdata2_o <= ex_opdata2;
      end else if (state_nxt == DONE) begin
        div_start_o <= 1'b0;
      end
      if (capture) begin
        hi_o <= div_res_i[63:32];
        lo_o <= div_res_i[31:0];
      end
      if (state_nxt == DONE) kill <= (state == ABORT) || flush;
    end
  end

  // Saturating wait counter; the sticky flag sets on the edge the count reaches the limit.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      wd_cnt        <= '0;
      div_timeout_o <= 1'b0;
    end else if (state == BUSY || state == ABORT) begin
      if (wd_cnt != CW'(WATCHDOG_CYCLES)) wd_cnt <= wd_cnt + CW'(1);
      if (wd_cnt == CW'(WATCHDOG_CYCLES - 1)) div_timeout_o <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized scoreboard bench for div_issue_ctrl with a behavioural divider and pipeline model.
module tb_div_issue_ctrl;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        ex_div_valid = 1'b0;
  logic        ex_div_signed = 1'b0;
  logic [31:0] ex_opdata1 = '0;
  logic [31:0] ex_opdata2 = '0;
  logic        flush = 1'b0;
  logic        div_ready_i = 1'b0;
  logic [63:0] div_res_i = '0;
  logic        div_start_o;
  logic        signed_div_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        stall_req_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_timeout_o;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;
  int          div_lat = 1;
  bit          div_hang = 1'b0;
  int          div_cnt = 0;
  bit          prev_launched = 1'b0;

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  div_issue_ctrl #(.WATCHDOG_CYCLES(48)) dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst      (cpu_rst),
    .ex_div_valid (ex_div_valid),
    .ex_div_signed(ex_div_signed),
    .ex_opdata1   (ex_opdata1),
    .ex_opdata2   (ex_opdata2),
    .flush        (flush),
    .div_ready_i  (div_ready_i),
    .div_res_i    (div_res_i),
    .div_start_o  (div_start_o),
    .signed_div_o (signed_div_o),
    .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o),
    .stall_req_o  (stall_req_o),
    .hilo_we_o    (hilo_we_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .div_timeout_o(div_timeout_o)
  );

  // {remainder, quotient}; truncating signed division, zero result for a zero divisor.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Divider: ready after div_lat cycles of held start, drops once start drops.
  always @(negedge cpu_clk_50M) begin
    if (!div_start_o || div_hang) begin
      div_cnt     = 0;
      div_ready_i = 1'b0;
    end else begin
      div_cnt++;
      if (div_cnt >= div_lat) begin
        div_ready_i = 1'b1;
        div_res_i   = div_ref(div_opdata1_o, div_opdata2_o, signed_div_o);
      end
    end
  end

  always @(negedge cpu_clk_50M) begin
    if (hilo_we_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual hi=%h lo=%h required no write", hi_o, lo_o);
      end else begin
        mon_exp = sb.pop_front();
        check("hilo_write", {hi_o, lo_o}, mon_exp);
      end
    end
  end

  // Holds the divide in EX until the stall releases it; flush_at is the EX cycle that sees flush (-1: none).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int lat, input int gap, input int flush_at);
    int n;
    int d;
    int n0;
    bit first_done;
    bit launched;
    bit flushed;
    bit s;
    for (int i = 0; i < gap; i++) @(negedge cpu_clk_50M);
    first_done = (gap == 0) && prev_launched;
    d  = first_done ? 1 : 0;
    n0 = lat + 1 + d;
    launched = !(flush_at >= 0 && flush_at <= d);
    div_lat = lat;
    if (!(flush_at >= 0 && flush_at < n0)) sb.push_back(div_ref(a, b, sgn));
    ex_div_valid  = 1'b1;
    ex_opdata1    = a;
    ex_opdata2    = b;
    ex_div_signed = sgn;
    n = 0;
    flushed = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (n == flush_at) begin
        flush   = 1'b1;
        flushed = 1'b1;
      end
      #1 s = stall_req_o;
      if (flushed) check("stall_on_flush", 64'(s), 64'(first_done && n == 0));
      @(negedge cpu_clk_50M);
      n++;
      flush = 1'b0;
      if (!s || flushed) break;
    end
    ex_div_valid = 1'b0;
    if (!flushed) begin
      check("issue_cycles", 64'(n), 64'(n0));
    end else if (launched) begin
      if (flush_at < n0 - 1) check("start_held_abort", 64'(div_start_o), 64'd1);
      for (int k = 0; k < 100; k++) begin
        if (!div_start_o) break;
        @(negedge cpu_clk_50M);
      end
      check("abort_drain", 64'(div_start_o), 64'd0);
    end
    #2 check("sb_drained", 64'(sb.size()), 64'd0);
    prev_launched = launched;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          rl;
    int          fa;

    repeat (3) @(negedge cpu_clk_50M);
    check("rst_ctrl", 64'({div_start_o, signed_div_o, stall_req_o, hilo_we_o, div_timeout_o}), 64'd0);
    check("rst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    cpu_rst = 1'b0;

    run_op(32'd100, 32'd7, 1'b0, 8, 1, -1);
    check("divu_100_7", {hi_o, lo_o}, {32'd2, 32'd14});
    run_op(-32'sd7, 32'd2, 1'b1, 5, 1, -1);
    check("div_m7_2", {hi_o, lo_o}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(32'd5, 32'd0, 1'b0, 3, 1, -1);
    check("divu_by_zero", {hi_o, lo_o}, 64'd0);
    check("no_timeout_dz", 64'(div_timeout_o), 64'd0);
    run_op(32'd100, 32'd3, 1'b0, 12, 1, 5);
    run_op(32'd9, 32'd3, 1'b0, 4, 1, -1);
    check("divu_9_3", {hi_o, lo_o}, {32'd0, 32'd3});
    run_op(32'd10, 32'd3, 1'b0, 4, 1, -1);
    check("b2b_first", {hi_o, lo_o}, {32'd1, 32'd3});
    run_op(32'd20, 32'd6, 1'b0, 4, 0, -1);
    check("b2b_second", {hi_o, lo_o}, {32'd2, 32'd3});
    run_op(32'd50, 32'd7, 1'b0, 4, 1, 4);
    check("ready_flush_capture", {hi_o, lo_o}, {32'd1, 32'd7});
    run_op(32'd1, 32'd1, 1'b0, 3, 1, 0);
    check("idle_flush_no_launch", 64'(div_start_o), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rs = 1'($urandom_range(0, 1));
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      rl = $urandom_range(1, 6);
      fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rl + 1) : -1;
      run_op(ra, rb, rs, rl, $urandom_range(0, 2), fa);
    end

    @(negedge cpu_clk_50M);
    div_hang     = 1'b1;
    ex_div_valid = 1'b1;
    ex_opdata1   = 32'd77;
    ex_opdata2   = 32'd7;
    repeat (48) @(negedge cpu_clk_50M);
    check("timeout_before_limit", 64'(div_timeout_o), 64'd0);
    @(negedge cpu_clk_50M);
    check("timeout_at_limit", 64'(div_timeout_o), 64'd1);
    check("stall_during_timeout", 64'(stall_req_o), 64'd1);
    ex_div_valid = 1'b0;
    #3 cpu_rst = 1'b1;
    #1 check("async_rst_ctrl", 64'({div_start_o, signed_div_o, stall_req_o, hilo_we_o, div_timeout_o}), 64'd0);
    check("async_rst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
    check("async_rst_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge cpu_clk_50M);
    cpu_rst       = 1'b0;
    div_hang      = 1'b0;
    prev_launched = 1'b0;

    run_op(32'd100, 32'd7, 1'b0, 3, 1, -1);
    check("recover_after_rst", {hi_o, lo_o}, {32'd2, 32'd14});
    check("timeout_cleared", 64'(div_timeout_o), 64'd0);

    repeat (3) @(negedge cpu_clk_50M);
    check("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Execute-stage controller that sits directly upstream and downstream of the iterative 32-bit divider.
- Detects a DIV/DIVU in EX and launches the divider with a level-held start.
- Stalls the pipeline until the divider reports ready, captures {remainder, quotient}, and issues a one-cycle HI/LO write.
- Handles pipeline flush mid-division by draining the divider safely.

Parameters:
WATCHDOG_CYCLES, 48, max cycles in BUSY/ABORT waiting for div_ready_i before div_timeout_o is flagged.

Ports:
cpu_clk_50M  in  1  system clock, all state on rising edge
cpu_rst  in  1  asynchronous, active-high reset
ex_div_valid  in  1  DIV/DIVU instruction present in EX this cycle
ex_div_signed  in  1  1 = DIV (signed), 0 = DIVU
ex_opdata1  in  32  dividend
ex_opdata2  in  32  divisor
flush  in  1  pipeline flush; kills the EX instruction
div_ready_i  in  1  divider result valid (level, held while start is high)
div_res_i  in  64  divider result {remainder[63:32], quotient[31:0]}
div_start_o  out  1  divider start, level; held until ready is seen
signed_div_o  out  1  registered signedness to divider
div_opdata1_o  out  32  registered dividend to divider
div_opdata2_o  out  32  registered divisor to divider
stall_req_o  out  1  combinational stall request to pipeline control
hilo_we_o  out  1  one-cycle HI/LO write enable
hi_o  out  32  remainder for HI
lo_o  out  32  quotient for LO
div_timeout_o  out  1  sticky watchdog error

Behaviour:
- Reset (async, cpu_rst=1): state=IDLE. All outputs 0, including div_start_o, operands, hi_o, lo_o, hilo_we_o and div_timeout_o. Watchdog counter 0. Reset mid-division abandons the operation; the divider shares the reset tree.
- States: IDLE, BUSY, DONE, ABORT.
- IDLE:
  - stall_req_o = ex_div_valid & ~flush.
  - If ex_div_valid & ~flush: latch ex_opdata1/2 and ex_div_signed into the operand registers, set div_start_o=1 (registered), go to BUSY.
- BUSY:
  - div_start_o=1; operand outputs stable.
  - If flush=1 and div_ready_i=0: go to ABORT; stall_req_o=0.
  - If div_ready_i=1: capture hi_o=div_res_i[63:32] and lo_o=div_res_i[31:0], div_start_o<=0, go to DONE; stall_req_o=0 this cycle so the instruction advances.
  - Otherwise stall_req_o=1.
  - Ready takes priority over a same-cycle flush: the result is captured, but hilo_we_o is suppressed in DONE because a kill flag is registered.
- DONE (exactly 1 cycle):
  - hilo_we_o=1 unless killed.
  - div_start_o=0 lets the divider return to its free state.
  - stall_req_o = ex_div_valid, so a back-to-back divide waits one cycle.
  - Next state: IDLE.
- ABORT:
  - div_start_o stays 1, because the divider only signals ready while start is held.
  - When div_ready_i=1: discard the result, div_start_o<=0, go to DONE with kill set (no write).
  - stall_req_o = ex_div_valid.
- Divide by zero: no special handling. The divider returns 0, so hi_o=lo_o=0 and hilo_we_o still pulses.
- Watchdog:
  - Counter increments each cycle in BUSY or ABORT and clears on entering IDLE.
  - When the counter reaches WATCHDOG_CYCLES, div_timeout_o<=1, sticky until reset. Behaviour otherwise unchanged.
- hi_o/lo_o hold their value until the next capture.
- hilo_we_o is high only in DONE.
- flush in IDLE with ex_div_valid: no launch, no stall.

Test Plan:
- DIVU 100/7: ex_div_valid for one issue cycle -> div_start_o high next cycle; stall_req_o high until ready; then hilo_we_o pulse with hi_o=2, lo_o=14; total under 24 cycles.
- DIV -7/2 signed -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, exactly one hilo_we_o pulse.
- Divisor 0 (DIVU 5/0) -> hi_o=lo_o=0, hilo_we_o pulses once, no timeout.
- flush 5 cycles into BUSY -> stall_req_o drops immediately; div_start_o held until ready, then dropped; no hilo_we_o; a following DIVU 9/3 completes with lo_o=3, hi_o=0.
- Back-to-back DIVU 10/3 then DIVU 20/6 -> first write hi=1/lo=3; second stalled through DONE and launched from IDLE; second write hi=2/lo=3.
- div_ready_i tied 0 -> div_timeout_o rises after 48 cycles in BUSY; assert cpu_rst mid-BUSY -> all outputs 0 asynchronously, state IDLE.
